// File: rtl/fibonacci_index_finder.sv
// Classifies a value as Fibonacci (and its index) by stepping the recurrence once per clock.
// Optional simulation print of each result: define FIB_INDEX_DISPLAY_EN.
module fibonacci_index_finder #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             is_fib,
  output logic [IDX_W-1:0] index
);

  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH:0]   prev_q, prev_d;
  logic [WIDTH:0]   cur_q, cur_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             is_fib_q, is_fib_d;
  logic [IDX_W-1:0] index_q, index_d;

  logic [WIDTH:0]   val_ext;
  assign val_ext = {1'b0, val_q};

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    prev_d   = prev_q;
    cur_d    = cur_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    is_fib_d = is_fib_q;
    index_d  = index_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          val_d   = value;
          prev_d  = '0;
          cur_d   = (WIDTH+1)'(1);
          idx_d   = IDX_W'(1);
          busy_d  = 1'b1;
          state_d = StSearch;
        end
      end
      StSearch: begin
        // Zero is checked first: the walk starts at F(1) and would never hit it.
        if (val_q == '0 || cur_q >= val_ext) begin
          is_fib_d = (val_q == '0) || (cur_q == val_ext);
          index_d  = (val_q == '0) ? '0 : idx_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end else begin
          prev_d = cur_q;
          cur_d  = cur_q + prev_q;
          idx_d  = idx_q + IDX_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      val_q    <= '0;
      prev_q   <= '0;
      cur_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_fib_q <= 1'b0;
      index_q  <= '0;
    end else begin
      state_q  <= state_d;
      val_q    <= val_d;
      prev_q   <= prev_d;
      cur_q    <= cur_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      is_fib_q <= is_fib_d;
      index_q  <= index_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign is_fib = is_fib_q;
  assign index  = index_q;

`ifdef FIB_INDEX_DISPLAY_EN
  always @(posedge clock) begin
    if (done_q) $display("Value =%d, is_fib=%b, index=%d", val_q, is_fib_q, index_q);
  end
`else
`endif

endmodule

// File: doc/fibonacci_index_finder.md
# fibonacci_index_finder

Inverse of the team's Fibonacci series generator: accepts a 20-bit value and determines, by iterating the Fibonacci recurrence, whether the value is a Fibonacci number and at which index. When the value is not a Fibonacci number, the block reports the index of the smallest Fibonacci number exceeding it. The block sits beside the generator as its checker/decoder and is used to close the loop on generated numbers.

## Interface
- WIDTH, 20, bit width of the input value.
- IDX_W, 8, bit width of the reported index.

- clock  input  1  rising-edge clock.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- value  input  WIDTH  number to classify; captured on the accepting edge.
- busy  output  1  high while a search is in progress.
- done  output  1  single-cycle pulse; result valid.
- is_fib  output  1  1 = value is a Fibonacci number.
- index  output  IDX_W  matching index, or the index of the first Fibonacci number greater than value.

## Operation
- Index convention: F(0)=0, F(1)=1, F(2)=1, F(3)=2 … F(30)=832040, F(31)=1346269. On a tie, the smallest index is reported, so value 1 gives index 1.
- Internal registers:
  - val_q is WIDTH bits.
  - prev and cur are WIDTH+1 bits. The sum never exceeds 2·val_q, so there is no overflow.
  - idx is IDX_W bits.
- FSM has two states, IDLE and SEARCH.
- IDLE:
  - If start=1: capture val_q<=value, then set prev<=0, cur<=1, idx<=1, busy<=1, and go to SEARCH.
  - If start=0: hold.
- SEARCH, evaluated once per clock, in this priority:
  - val_q==0: is_fib<=1, index<=0, finish.
  - cur==val_q: is_fib<=1, index<=idx, finish.
  - cur>val_q: is_fib<=0, index<=idx, finish.
  - otherwise: prev<=cur, cur<=cur+prev, idx<=idx+1, and stay in SEARCH.
- Finish: on the same edge, done<=1, busy<=0, and go to IDLE.
- Outputs:
  - done is cleared on the next edge.
  - is_fib and index hold until the next finish or reset.
- start while busy is ignored. No queuing.
- Changes to value after the accepting edge have no effect.
- start high in the cycle done is high is accepted, because the FSM is already in IDLE. Back-to-back operation is therefore legal.

## Timing
- Reset (async assert, sync-free release): state=IDLE, busy=0, done=0, is_fib=0, index=0, and internal registers cleared.
- Reset asserted mid-search aborts immediately. No done pulse is produced for the aborted request.
- Let E0 be the edge accepting start:
  - busy is high from after E0 until after E_k.
  - done is high for exactly the cycle following E_k.
  - k=1 for value 0.
  - k=n for a match at index n.
  - k=m for a non-match, where m is the reported index.
- Worst-case latency with default WIDTH: k=31, for values 832041..1048575.
- Throughput: one request per k+1 cycles, counting from start to the next accepted start.

## Configuration
- FIB_INDEX_DISPLAY_EN:
  - Defined: a simulation-only block prints "Value =%d, is_fib=%b, index=%d" on each cycle where done=1.
  - Undefined: no display code is compiled. Hardware behaviour is identical in both builds.

## Test plan
- value=0, start for 1 cycle -> done after E1, is_fib=1, index=0; busy high only between E0 and E1.
- value=1 -> done after E1, is_fib=1, index=1; value=13 -> done after E7, is_fib=1, index=7.
- value=832040 -> done after E30, is_fib=1, index=30; results hold through 5 idle cycles.
- value=4 -> done after E5, is_fib=0, index=5. Then start is asserted in the done cycle with value=21 -> accepted, is_fib=1, index=8.
- value=20'hFFFFF -> done after E31, is_fib=0, index=31. A start pulse with value=2 at cycle 10 is ignored, and exactly one done pulse is observed.
- value=100000, reset_n low for 2 cycles at cycle 12 -> busy, done, is_fib and index go to 0 asynchronously, and no done pulse occurs. After release, value=55 -> is_fib=1, index=10.
